// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the bit-counter width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // A one-bit counter is still needed when WIDTH=1.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder built from explicit xor/and/or terms; the one
// arithmetic cell shared across all bit positions of the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  assign ab_x = a ^ b;
  assign ab_a = a & b;
  assign cx_a = ab_x & cin;
  assign s    = ab_x ^ cin;
  assign cout = ab_a | cx_a;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell walks a WIDTH-bit operand
// pair LSB first. Define SERIAL_ADD_OVF_EN to add the signed overflow output.
//
// Handshake: start is sampled only in IDLE; the accepting edge captures
// a/b/cin. done is a one-cycle pulse during which sum/cout (and ovf) are
// valid; they then hold until the next accepted operation completes.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q;
  logic [WIDTH-1:0] sum_sr_d;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fa_s, fa_c;
  logic             last_bit;

  full_adder_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == FIN);
    dbg_state = state_q;
  end

  // Result registers load on the final RUN edge so that sum/cout are already
  // valid in the FIN cycle, alongside the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          sum_sr_q <= sum_sr_d;
          carry_q  <= fa_c;
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit) begin
            sum_q  <= sum_sr_d;
            cout_q <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // carry_q is the carry into the MSB while the last bit is being summed.
  always_ff @(posedge clk) begin
    if (rst)                              ovf_q <= 1'b0;
    else if ((state_q == RUN) && last_bit) ovf_q <= carry_q ^ fa_c;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: a WIDTH=8 and a WIDTH=1 instance share
// one clock; expected results are hand-computed constants.
module tb_serial_add_ctrl;

  logic clk;
  logic rst;

  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic [1:0] st8;

  logic       start1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  logic [1:0] st1;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf8, ovf1;
`endif

  int errors;
  int checks;
  logic [31:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .busy      (busy8),
    .done      (done8),
    .sum       (sum8),
    .cout      (cout8),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf8),
`endif
    .dbg_state (st8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .busy      (busy1),
    .done      (done1),
    .sum       (sum1),
    .cout      (cout1),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf1),
`endif
    .dbg_state (st1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one WIDTH=8 operation and checks busy length, done and results.
  // Expected packed as {ovf, cout, sum}.
  task automatic op8(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                     input logic c_v, input logic [7:0] es, input logic ec, input logic eo);
    int nb;
    logic [31:0] e;
    exp_q.push_back({22'd0, eo, ec, es});
    @(negedge clk);
    a8 = a_v; b8 = b_v; cin8 = c_v; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    nb = 0;
    while (busy8 && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check({tag, " busy_cycles"}, nb, 8);
    check({tag, " done"}, {31'd0, done8}, 1);
    check({tag, " sum"}, {24'd0, sum8}, {24'd0, e[7:0]});
    check({tag, " cout"}, {31'd0, cout8}, {31'd0, e[8]});
`ifdef SERIAL_ADD_OVF_EN
    check({tag, " ovf"}, {31'd0, ovf8}, {31'd0, e[9]});
`endif
    @(negedge clk);
    check({tag, " done_pulse_end"}, {31'd0, done8}, 0);
  endtask

  initial begin
    int ndone;
    errors = 0; checks = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst busy", {31'd0, busy8}, 0);
    check("rst done", {31'd0, done8}, 0);
    check("rst sum", {24'd0, sum8}, 0);
    check("rst cout", {31'd0, cout8}, 0);
    check("rst state", {30'd0, st8}, 0);

    op8("5a+3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    op8("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("ff+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

    // Start and operand changes during RUN must be ignored.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    check("ign sum_held", {24'd0, sum8}, 0);
    check("ign cout_held", {31'd0, cout8}, 1);
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        ndone++;
        check("ign sum", {24'd0, sum8}, 32'h30);
        check("ign cout", {31'd0, cout8}, 0);
      end
      @(negedge clk);
    end
    check("ign done_count", ndone, 1);

    // Reset in RUN cycle 4 aborts with no done pulse.
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort busy_before", {31'd0, busy8}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {31'd0, busy8}, 0);
    check("abort done", {31'd0, done8}, 0);
    check("abort sum", {24'd0, sum8}, 0);
    check("abort cout", {31'd0, cout8}, 0);
    check("abort state", {30'd0, st8}, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    check("abort no_done", ndone, 0);
    op8("post_abort 12+34+1", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
    op8("ovf 7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("ovf 80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op8("ovf 05+fb", 8'h05, 8'hFB, 1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // WIDTH=1: 1+1+1, then a start in the idle cycle after done.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("w1 c1 busy", {31'd0, busy1}, 1);
    check("w1 c1 done", {31'd0, done1}, 0);
    @(negedge clk);
    check("w1 c2 done", {31'd0, done1}, 1);
    check("w1 c2 busy", {31'd0, busy1}, 0);
    check("w1 sum", {31'd0, sum1}, 1);
    check("w1 cout", {31'd0, cout1}, 1);
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
    check("w1 c3 done", {31'd0, done1}, 0);
    @(negedge clk);
    start1 = 1'b0;
    check("w1 b2b busy", {31'd0, busy1}, 1);
    @(negedge clk);
    check("w1 b2b done", {31'd0, done1}, 1);
    check("w1 b2b sum", {31'd0, sum1}, 1);
    check("w1 b2b cout", {31'd0, cout1}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
